nibble_serial_addsub: RTL
=========================

// Module: nibble_serial_addsub
// PURPOSE
//  Nibble-serial sequencer that performs a WIDTH-bit signed add/subtract using the team's
//  existing 4-bit addsub slice. It loads two operands on a start handshake, then feeds one
//  nibble per cycle, LSB first, into the external slice, chaining slice carry-out to the next
//  carry-in. It collects the slice sum nibbles into a WIDTH-bit result plus carry and signed
//  overflow flags. It sits directly upstream of the addsub slice and consumes its outputs.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous active-high reset
//  start       in   1      request; accepted only when ready=1
//  ready       out  1      1 in IDLE
//  sub         in   1      0 = add, 1 = subtract (a - b); sampled with start
//  opa         in   WIDTH  signed operand a; sampled with start
//  opb         in   WIDTH  signed operand b; sampled with start
//  result      out  WIDTH  signed result; held from done until next accepted start
//  co          out  1      final carry-out (subtract: 1 = no borrow)
//  oflow       out  1      signed overflow of full-width operation
//  done        out  1      one-cycle pulse; result/co/oflow valid from this cycle
//  slice_a     out  4      current nibble of a to slice
//  slice_b     out  4      current nibble of b to slice (uninverted; slice applies sub)
//  slice_sub   out  1      registered sub to slice
//  slice_ci    out  1      chained carry-in to slice
//  slice_z     in   4      slice sum nibble
//  slice_co    in   1      slice carry-out
//  slice_oflow in   1      slice signed overflow; used on last nibble only
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; ready=1; result=0, co=0, oflow=0, done=0; slice_* outputs=0.
//  - FSM states: IDLE -> RUN on start&ready. RUN lasts NIB=WIDTH/4 cycles, then goes to DONE.
//    DONE lasts 1 cycle (done=1), then returns to IDLE.
//  - Accept edge: load a_sh=opa, b_sh=opb, sub_r=sub, carry_r=sub, cnt=0.
//    At the same edge, clear result, co and oflow.
//  - RUN, each cycle:
//    - drive slice_a=a_sh[3:0], slice_b=b_sh[3:0], slice_sub=sub_r, slice_ci=carry_r;
//    - at the edge, shift a_sh and b_sh right by 4;
//    - shift slice_z into result[WIDTH-1:WIDTH-4] (result shifts right by 4);
//    - carry_r<=slice_co; cnt++.
//  - Last nibble (cnt==NIB-1): co<=slice_co, oflow<=slice_oflow; next state DONE.
//  - slice_* outputs read 0 outside RUN.
//  - Latency: start accepted at edge k -> done=1 in the cycle after edge k+NIB; ready=1 again one cycle later.
//  - start while ready=0 is ignored, and operands are not sampled.
//    start in the DONE cycle is also ignored.
//  - result/co/oflow are stable from done until the next accept edge.
//  - Reset mid-RUN aborts immediately: no done pulse, and all outputs go to their reset values.
//  - Wrap-around: carry out of the MSB is discarded from result and reported only on co.
// CONFIGURATION
//  - Macro NSAS_SATURATE_EN, if defined: when the final oflow=1, result is clamped.
//    Clamp to 2^(WIDTH-1)-1 if opa's sign bit=0, else to -2^(WIDTH-1).
//    Clamp is applied at the last-nibble edge; oflow and co are still reported unchanged.
//  - Macro undefined: result is the wrapped two's-complement value.
// STRUCTURE
//  - Shared package nsas_pkg:
//    - state typedef {IDLE, RUN, DONE};
//    - NIB_BITS constant = 4;
//    - function clog2 for the cnt width.
//  - One natural sub-module: nibble_shreg (loadable 4-bit-per-shift right shift register, WIDTH wide).
//    Instantiated three times: a_sh, b_sh, result.
//  - The addsub slice stays outside this block; the bench connects it via the slice_* ports.
// TESTING  (WIDTH=16, real addsub slice attached)
//  - add 0x7FFF+0x0001 -> result 0x8000, co=0, oflow=1; done exactly 5 cycles after accept edge.
//  - sub 0x0005-0x0003 -> result 0x0002, co=1, oflow=0; slice_ci=1 on first nibble.
//  - add 0xFFFF+0x0001 -> result 0x0000, co=1, oflow=0.
//    Check carry ripples through all 4 nibbles (slice_ci=1 on nibbles 1..3).
//  - sub 0x8000-0x0001 -> oflow=1; result 0x7FFF (macro off) / 0x8000 (NSAS_SATURATE_EN).
//  - start pulsed at cycles 2 and 3 of RUN with different operands -> ignored; first result unchanged.
//  - rst asserted in RUN cycle 2 -> outputs 0 immediately, no done.
//    The next start completes a correct 0x1234+0x1111=0x2345.

Source files
------------

// File: rtl/nsas_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_t  : sequencer states (IDLE, RUN, DONE)
//   NIB_BITS : bits handled per slice operation
//   clog2    : ceiling log2 used to size the nibble counter (never below 1)
package nsas_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIB_BITS = 4;

  // Returns at least 1 so a single-nibble counter still has a legal width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle for nibble_serial_addsub.
//   start/sub/opa/opb : request side, driven by the requester (master)
//   ready/result/co/oflow/done : response side, driven by the sequencer (slave)
interface nibble_serial_addsub_if #(parameter int WIDTH = 16);

  logic             start;
  logic             ready;
  logic             sub;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             oflow;
  logic             done;

  modport master (output start, sub, opa, opb,
                  input  ready, result, co, oflow, done);

  modport slave  (input  start, sub, opa, opb,
                  output ready, result, co, oflow, done);

endinterface

// File: rtl/nibble_shreg.sv
// Loadable right shift register that moves NIB_BITS bits per shift.
//   clk, rst  : clock, asynchronous active-high reset (clears to 0)
//   load      : load load_val (takes priority over shift)
//   shift     : shift right by NIB_BITS, shift_in enters at the MSB nibble
//   q         : register contents
module nibble_shreg
  import nsas_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                shift,
  input  logic [NIB_BITS-1:0] shift_in,
  output logic [WIDTH-1:0]    q
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {shift_in, data_q[WIDTH-1:NIB_BITS]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit signed add/subtract sequencer driving an external 4-bit
// addsub slice, LSB nibble first, with the slice carry chained between nibbles.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : start/ready handshake, sub/opa/opb request, result/co/oflow/done
//   slice_a/b       : current operand nibbles (b uninverted; the slice applies sub)
//   slice_sub/ci    : registered operation and chained carry-in
//   slice_z/co/oflow: slice sum nibble, carry-out, signed overflow (last nibble only)
// Optional feature: define NSAS_SATURATE_EN to clamp result on signed overflow.
module nibble_serial_addsub
  import nsas_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_addsub_if.slave bus,
  output logic [NIB_BITS-1:0]   slice_a,
  output logic [NIB_BITS-1:0]   slice_b,
  output logic                  slice_sub,
  output logic                  slice_ci,
  input  logic [NIB_BITS-1:0]   slice_z,
  input  logic                  slice_co,
  input  logic                  slice_oflow
);

  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int CNT_W = clog2(NIB);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             oflow_q, oflow_d;

  logic             accept;
  logic             run;
  logic             last;
  logic [WIDTH-1:0] a_sh, b_sh, result_sh;
  logic             res_load;
  logic [WIDTH-1:0] res_load_val;
  logic             unused_hi;

  assign accept = (state_q == IDLE) && bus.start;
  assign run    = (state_q == RUN);
  assign last   = run && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    co_d    = co_q;
    oflow_d = oflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          sub_d   = bus.sub;
          // Subtract is a + ~b + 1: the +1 enters as the first carry-in.
          carry_d = bus.sub;
          co_d    = 1'b0;
          oflow_d = 1'b0;
        end
      end
      RUN: begin
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          co_d    = slice_co;
          oflow_d = slice_oflow;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      oflow_q <= oflow_d;
    end
  end

`ifdef NSAS_SATURATE_EN
  // opa's sign is lost from a_sh as it shifts, so keep it for the clamp direction.
  logic a_sign_q, a_sign_d;

  always_comb begin
    a_sign_d = accept ? bus.opa[WIDTH-1] : a_sign_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign_q <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
    end
  end

  // Clamp overrides the final shift when the full-width operation overflows.
  always_comb begin
    res_load     = accept;
    res_load_val = '0;
    if (last && slice_oflow) begin
      res_load     = 1'b1;
      res_load_val = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res_load     = accept;
    res_load_val = '0;
  end
`endif

  nibble_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (bus.opa),
    .shift    (run),
    .shift_in ('0),
    .q        (a_sh)
  );

  nibble_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (bus.opb),
    .shift    (run),
    .shift_in ('0),
    .q        (b_sh)
  );

  // Sum nibbles enter at the top, so after NIB shifts the LSB nibble lands at the bottom.
  nibble_shreg #(.WIDTH(WIDTH)) u_result_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (res_load),
    .load_val (res_load_val),
    .shift    (run),
    .shift_in (slice_z),
    .q        (result_sh)
  );

  // Only the low nibble of each operand register ever reaches the slice.
  assign unused_hi = ^{a_sh[WIDTH-1:NIB_BITS], b_sh[WIDTH-1:NIB_BITS]};

  assign slice_a   = run ? a_sh[NIB_BITS-1:0] : '0;
  assign slice_b   = run ? b_sh[NIB_BITS-1:0] : '0;
  assign slice_sub = run & sub_q;
  assign slice_ci  = run & carry_q;

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_sh;
  assign bus.co     = co_q;
  assign bus.oflow  = oflow_q;

endmodule
